lstm_job_sched: RTL

Job scheduler that sequences the main-memory DMA controller and the LSTM core through one complete inference job. On `go` it loads the weight block once. It then loops over `steps` timesteps; each timestep loads a feature vector, starts the LSTM, waits for `lstm_done`, and stores the result vector. The block sits between the host/top-level control and the DMA controller plus LSTM core. It owns the DMA controller's `start`, `direct`, `main_mem_count` and `main_mem_first_address` inputs.

---
 rtl/lstm_job_sched.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/lstm_job_sched.sv
// lstm_job_sched: sequences the DMA controller and the LSTM core through one
// inference job. The weight block is loaded once, then every timestep loads a
// feature vector, runs the LSTM until it reports completion, stores the result
// vector and spends one drain cycle before the next timestep or job completion.
module lstm_job_sched #(
    parameter int MAIN_MEM_ADD_LEN = 11,
    parameter int FEATURES         = 4,
    parameter int WEIGHTS          = 64
) (
    input  logic                        fpga_clk,
    input  logic                        reset,
    input  logic                        go,
    input  logic [7:0]                  steps,
    input  logic [MAIN_MEM_ADD_LEN-1:0] weights_base,
    input  logic [MAIN_MEM_ADD_LEN-1:0] features_base,
    input  logic [MAIN_MEM_ADD_LEN-1:0] results_base,
    input  logic                        lstm_done,
    output logic                        dmac_start,
    output logic                        dmac_direct,
    output logic [MAIN_MEM_ADD_LEN-1:0] dmac_count,
    output logic [MAIN_MEM_ADD_LEN-1:0] dmac_first_address,
    output logic                        lstm_start,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  phase,
    output logic [7:0]                  step_idx
);

    localparam int L = MAIN_MEM_ADD_LEN;

    localparam logic [L-1:0] C_WEIGHTS = L'(WEIGHTS);
    localparam logic [L-1:0] C_FEAT    = L'(FEATURES);
    localparam logic [L-1:0] C_WLAST   = L'(WEIGHTS - 1);
    localparam logic [L-1:0] C_FLAST   = L'(FEATURES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_W  = 3'd1,
        S_LD_F  = 3'd2,
        S_RUN   = 3'd3,
        S_ST    = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t         r_state;
    logic [L-1:0]   r_beat;
    logic [7:0]     r_steps;
    logic [7:0]     r_stepIdx;
    logic [L-1:0]   r_featBase;
    logic [L-1:0]   r_resBase;
    logic           r_dmacStart;
    logic           r_dmacDirect;
    logic [L-1:0]   r_dmacCount;
    logic [L-1:0]   r_dmacAddr;
    logic           r_lstmStart;
    logic           r_done;

    logic [L-1:0]   w_curOff;
    logic [L-1:0]   w_nxtOff;
    logic           w_lastStep;

    // Vector offsets of the current and the following timestep; both wrap
    // modulo the address space like the rest of the address arithmetic.
    assign w_curOff   = L'(32'(r_stepIdx) * FEATURES);
    assign w_nxtOff   = L'((32'(r_stepIdx) + 32'd1) * FEATURES);
    assign w_lastStep = (r_stepIdx == r_steps - 8'd1);

    // Job sequencer: state, beat counter, latched job parameters and all
    // registered outputs are updated together so every output lines up with
    // the state it belongs to on the same cycle.
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_beat       <= '0;
            r_steps      <= '0;
            r_stepIdx    <= '0;
            r_featBase   <= '0;
            r_resBase    <= '0;
            r_dmacStart  <= 1'b0;
            r_dmacDirect <= 1'b0;
            r_dmacCount  <= '0;
            r_dmacAddr   <= '0;
            r_lstmStart  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_dmacStart <= 1'b0;
            r_lstmStart <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go && (steps != 8'd0)) begin
                        r_steps      <= steps;
                        r_featBase   <= features_base;
                        r_resBase    <= results_base;
                        r_stepIdx    <= '0;
                        r_beat       <= '0;
                        r_state      <= S_LD_W;
                        r_dmacStart  <= 1'b1;
                        r_dmacDirect <= 1'b0;
                        r_dmacCount  <= C_WEIGHTS;
                        r_dmacAddr   <= weights_base;
                    end
                end
                S_LD_W: begin
                    if (r_beat == C_WLAST) begin
                        r_beat       <= '0;
                        r_state      <= S_LD_F;
                        r_dmacStart  <= 1'b1;
                        r_dmacDirect <= 1'b0;
                        r_dmacCount  <= C_FEAT;
                        r_dmacAddr   <= r_featBase + w_curOff;
                    end else begin
                        r_beat <= r_beat + L'(1);
                    end
                end
                S_LD_F: begin
                    if (r_beat == C_FLAST) begin
                        r_beat       <= '0;
                        r_state      <= S_RUN;
                        r_lstmStart  <= 1'b1;
                        r_dmacDirect <= 1'b0;
                        r_dmacCount  <= '0;
                        r_dmacAddr   <= '0;
                    end else begin
                        r_beat <= r_beat + L'(1);
                    end
                end
                S_RUN: begin
                    // A done pulse coinciding with the start pulse cannot
                    // belong to this timestep, so the first cycle ignores it.
                    if (r_beat == '0) begin
                        r_beat <= L'(1);
                    end else if (lstm_done) begin
                        r_beat       <= '0;
                        r_state      <= S_ST;
                        r_dmacStart  <= 1'b1;
                        r_dmacDirect <= 1'b1;
                        r_dmacCount  <= C_FEAT;
                        r_dmacAddr   <= r_resBase + w_curOff;
                    end
                end
                S_ST: begin
                    if (r_beat == C_FLAST) begin
                        r_beat       <= '0;
                        r_state      <= S_DRAIN;
                        r_dmacDirect <= 1'b0;
                        r_dmacCount  <= '0;
                        r_dmacAddr   <= '0;
                        r_done       <= w_lastStep;
                    end else begin
                        r_beat <= r_beat + L'(1);
                    end
                end
                S_DRAIN: begin
                    if (w_lastStep) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_stepIdx    <= r_stepIdx + 8'd1;
                        r_state      <= S_LD_F;
                        r_dmacStart  <= 1'b1;
                        r_dmacDirect <= 1'b0;
                        r_dmacCount  <= C_FEAT;
                        r_dmacAddr   <= r_featBase + w_nxtOff;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_beat  <= '0;
                end
            endcase
        end
    end

    assign dmac_start         = r_dmacStart;
    assign dmac_direct        = r_dmacDirect;
    assign dmac_count         = r_dmacCount;
    assign dmac_first_address = r_dmacAddr;
    assign lstm_start         = r_lstmStart;
    assign done               = r_done;
    assign step_idx           = r_stepIdx;
    assign phase              = r_state;
    assign busy               = (r_state != S_IDLE);

endmodule
